smi_responder: RTL
==================

Name: smi_responder

Overview:
- PHY-side (management slave) end of the IEEE 802.3 Clause 22 SMI/MDIO interface; counterpart to the station-management master.
- Oversamples MDC/MDIO on the system clock and decodes preamble, ST, OP, PHYAD, REGAD, TA and DATA.
- Answers reads from a small internal register file and applies writes to it.
- Used as an on-chip PHY stand-in for loopback and bench checking of the master, and as a management target on a debug header.

Parameters:
- NUM_REGS, 8, number of implemented 16-bit registers at REGAD 0..NUM_REGS-1 (max 32).
- PHY_ID, 32'h0007_C0F1, value returned read-only at REGAD 2 (bits 31:16) and REGAD 3 (bits 15:0).
- PREAMBLE_LEN, 32, consecutive 1 bits required before ST.

Ports:
- clk_100mhz  input  1  system clock, 100 MHz; reset is synchronous and active-high, sampled on this clock.
- rst  input  1  synchronous active-high reset.
- mdc  input  1  management clock from master, asynchronous, at most 2.5 MHz.
- mdio_i  input  1  MDIO pad input.
- mdio_o  output  1  MDIO pad output value.
- mdio_oe  output  1  MDIO pad output enable; 1 = drive mdio_o, 0 = release.
- phy_addr  input  5  this device's PHYAD; static while a frame is in progress.
- wr_strobe  output  1  one-cycle pulse when an addressed write completes.
- wr_reg_addr  output  5  REGAD of the last write; valid while wr_strobe is high.
- wr_data  output  16  data of the last write; valid while wr_strobe is high.
- rd_strobe  output  1  one-cycle pulse when an addressed read is accepted, at the end of REGAD.
- debug_state  output  3  current FSM state encoding.

Behaviour:
- Input synchronisation
  - mdc and mdio_i each pass through a 2-flop synchroniser.
  - An MDC rising edge is detected on the synchronised mdc, one register later than the synchroniser output.
  - Synchronised mdio is sampled on the same cycle as the rise event, so the sample is aligned with the master's rising edge.
  - Total latency from pin edge to event is 3 clk_100mhz cycles.
- All FSM state changes occur only on rise events, except reset.
- FSM states and encodings:
  - IDLE=0: count consecutive 1 bits, saturating at PREAMBLE_LEN.
    - A 1 increments the count.
    - A 0 with count >= PREAMBLE_LEN goes to ST.
    - A 0 with count below PREAMBLE_LEN clears the count.
  - ST=1: expects the second start bit.
    - 1 goes to OP.
    - 0 goes to IDLE with count cleared.
  - OP=2: collects 2 bits.
    - 10 = read, 01 = write.
    - 00 or 11 goes to IDLE with count cleared; the frame is ignored.
  - ADDR=3: collects 5 PHYAD bits then 5 REGAD bits, MSB first.
    - The frame is "addressed" when PHYAD equals phy_addr.
    - On the 10th bit of an addressed read: latch the read word and pulse rd_strobe.
  - TA=4: two bit times.
    - Read, addressed: at the rise ending TA bit 1, set mdio_oe=1 and mdio_o=0.
    - Write: TA bits are sampled and ignored; a bad TA is not checked.
  - DATA=5: 16 bit times.
    - Read, addressed:
      - At the rise ending TA bit 2, drive bit 15.
      - Each subsequent rise shifts to the next bit.
      - At the rise ending bit 0, set mdio_oe=0.
    - Write: shift in 16 bits MSB first.
      - After the 16th bit, for an addressed frame, update the register file and pulse wr_strobe, wr_reg_addr and wr_data on the same cycle.
    - After the final data bit, go to IDLE with count cleared; a fresh preamble is required.
- Unaddressed frames traverse every state silently, with mdio_oe=0 throughout, to stay aligned.
- Register file:
  - REGAD 2 and 3 read PHY_ID halves; writes to them are discarded, but wr_strobe still pulses.
  - REGAD >= NUM_REGS reads 16'h0000; writes are discarded, but wr_strobe still pulses.
  - The latched read word is not affected by writes from other logic during the read.
- Reset values:
  - FSM in IDLE with count 0.
  - mdio_oe=0, mdio_o=1.
  - wr_strobe=0, rd_strobe=0.
  - wr_reg_addr=0, wr_data=0.
  - All registers 0 except the PHY_ID reads.
- Reset mid-frame: the bus is released on the following cycle and any partial write is dropped.
- Stalled MDC: there is no timeout; state is held indefinitely.

Optional Feature:
- Macro: SMI_RESPONDER_PREAMBLE_SUPPRESSION_EN.
- Defined: in IDLE, a 0 following at least one 1 goes to ST regardless of count. This supports masters that send a shortened preamble after the first frame.
- Undefined: the full PREAMBLE_LEN ones are mandatory, as described above.

Test Plan:
- phy_addr=1; write REGAD 1 = 16'hA5C3 with 32-bit preamble -> wr_strobe pulses once with wr_reg_addr=1, wr_data=16'hA5C3; a subsequent read of REGAD 1 returns 16'hA5C3 with MDIO driven 0 in TA bit 2.
- Read REGAD 2 then REGAD 3 -> 16'h0007 then 16'hC0F1; mdio_oe high for exactly 17 MDC periods per read.
- Read with PHYAD=5 while phy_addr=1 -> mdio_oe stays 0 for the whole frame, no strobes; the next valid frame decodes correctly.
- Preamble of 31 ones then ST -> frame ignored, no strobes. With SMI_RESPONDER_PREAMBLE_SUPPRESSION_EN defined and a 1-bit preamble -> frame accepted.
- OP=11 frame followed by a valid write of 16'h1234 to REGAD 0 -> the first frame is ignored, the second produces wr_data=16'h1234.
- Assert rst during read data bit 8 -> mdio_oe=0 on the next cycle, FSM in IDLE, registers cleared; a following full read of REGAD 0 returns 16'h0000.

Source files
------------

// File: rtl/smi_responder.sv
// Clause 22 SMI/MDIO management slave: oversamples MDC/MDIO, decodes frames, serves a register file.
// Optional: define SMI_RESPONDER_PREAMBLE_SUPPRESSION_EN to accept a shortened preamble.
`timescale 1ns/1ps

module smi_responder #(
    parameter int unsigned NUM_REGS     = 8,
    parameter logic [31:0] PHY_ID       = 32'h0007_C0F1,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic        clk_100mhz,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [4:0]  phy_addr,
    output logic        wr_strobe,
    output logic [4:0]  wr_reg_addr,
    output logic [15:0] wr_data,
    output logic        rd_strobe,
    output logic [2:0]  debug_state
);

    localparam int unsigned PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StSt   = 3'd1,
        StOp   = 3'd2,
        StAddr = 3'd3,
        StTa   = 3'd4,
        StData = 3'd5
    } state_e;

    // Synchroniser, edge detector and aligned data sample
    logic [1:0] mdc_sync_q;
    logic [1:0] mdio_sync_q;
    logic       mdc_prev_q;
    logic       rise_q;
    logic       bit_q;

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            mdc_sync_q  <= 2'b00;
            mdio_sync_q <= 2'b11;
            mdc_prev_q  <= 1'b0;
            rise_q      <= 1'b0;
            bit_q       <= 1'b1;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[0], mdc};
            mdio_sync_q <= {mdio_sync_q[0], mdio_i};
            mdc_prev_q  <= mdc_sync_q[1];
            rise_q      <= mdc_sync_q[1] & ~mdc_prev_q;
            bit_q       <= mdio_sync_q[1];
        end
    end

    state_e             state_q;
    logic [PRE_W-1:0]   pre_cnt_q;
    logic [3:0]         bit_cnt_q;
    logic               op_hi_q;
    logic               is_read_q;
    logic               addressed_q;
    logic [8:0]         addr_sr_q;
    logic [4:0]         reg_addr_q;
    logic [15:0]        data_sr_q;
    logic [15:0]        rd_word_q;
    logic [15:0]        regs_q [NUM_REGS];

    logic               preamble_ok;
    logic [4:0]         phyad_w;
    logic [4:0]         regad_w;
    logic [15:0]        rd_value;
    logic [15:0]        wr_word;
    logic               reg_writable;

`ifdef SMI_RESPONDER_PREAMBLE_SUPPRESSION_EN
    assign preamble_ok = (pre_cnt_q != '0);
`else
    assign preamble_ok = (pre_cnt_q >= PRE_W'(PREAMBLE_LEN));
`endif

    // Address fields are only meaningful on the 10th ADDR bit
    assign phyad_w = addr_sr_q[8:4];
    assign regad_w = {addr_sr_q[3:0], bit_q};
    assign wr_word = {data_sr_q[14:0], bit_q};

    always_comb begin
        rd_value = 16'h0000;
        if (regad_w == 5'd2) begin
            rd_value = PHY_ID[31:16];
        end else if (regad_w == 5'd3) begin
            rd_value = PHY_ID[15:0];
        end else if (32'(regad_w) < NUM_REGS) begin
            rd_value = regs_q[regad_w[IDX_W-1:0]];
        end
    end

    assign reg_writable = (32'(reg_addr_q) < NUM_REGS) && (reg_addr_q != 5'd2) &&
                          (reg_addr_q != 5'd3);

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q     <= StIdle;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= 4'd0;
            op_hi_q     <= 1'b0;
            is_read_q   <= 1'b0;
            addressed_q <= 1'b0;
            addr_sr_q   <= '0;
            reg_addr_q  <= '0;
            data_sr_q   <= '0;
            rd_word_q   <= '0;
            mdio_o      <= 1'b1;
            mdio_oe     <= 1'b0;
            wr_strobe   <= 1'b0;
            rd_strobe   <= 1'b0;
            wr_reg_addr <= '0;
            wr_data     <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            if (rise_q) begin
                unique case (state_q)
                    StIdle: begin
                        if (bit_q) begin
                            if (pre_cnt_q < PRE_W'(PREAMBLE_LEN)) begin
                                pre_cnt_q <= pre_cnt_q + 1'b1;
                            end
                        end else begin
                            pre_cnt_q <= '0;
                            if (preamble_ok) begin
                                state_q <= StSt;
                            end
                        end
                    end
                    StSt: begin
                        bit_cnt_q <= 4'd0;
                        state_q   <= bit_q ? StOp : StIdle;
                    end
                    StOp: begin
                        if (bit_cnt_q == 4'd0) begin
                            op_hi_q   <= bit_q;
                            bit_cnt_q <= 4'd1;
                        end else begin
                            bit_cnt_q <= 4'd0;
                            is_read_q <= op_hi_q;
                            // 10 = read, 01 = write; anything else abandons the frame
                            state_q   <= (op_hi_q != bit_q) ? StAddr : StIdle;
                        end
                    end
                    StAddr: begin
                        addr_sr_q <= {addr_sr_q[7:0], bit_q};
                        if (bit_cnt_q == 4'd9) begin
                            bit_cnt_q   <= 4'd0;
                            reg_addr_q  <= regad_w;
                            addressed_q <= (phyad_w == phy_addr);
                            if (is_read_q && (phyad_w == phy_addr)) begin
                                rd_word_q <= rd_value;
                                rd_strobe <= 1'b1;
                            end
                            state_q <= StTa;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    StTa: begin
                        if (bit_cnt_q == 4'd0) begin
                            bit_cnt_q <= 4'd1;
                            if (is_read_q && addressed_q) begin
                                mdio_oe <= 1'b1;
                                mdio_o  <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= 4'd0;
                            state_q   <= StData;
                            if (is_read_q && addressed_q) begin
                                mdio_o    <= rd_word_q[15];
                                data_sr_q <= {rd_word_q[14:0], 1'b0};
                            end else begin
                                data_sr_q <= '0;
                            end
                        end
                    end
                    StData: begin
                        if (is_read_q) begin
                            if (addressed_q) begin
                                mdio_o    <= data_sr_q[15];
                                data_sr_q <= {data_sr_q[14:0], 1'b0};
                            end
                        end else begin
                            data_sr_q <= wr_word;
                        end
                        if (bit_cnt_q == 4'd15) begin
                            bit_cnt_q <= 4'd0;
                            pre_cnt_q <= '0;
                            state_q   <= StIdle;
                            mdio_oe   <= 1'b0;
                            mdio_o    <= 1'b1;
                            if (!is_read_q && addressed_q) begin
                                wr_strobe   <= 1'b1;
                                wr_reg_addr <= reg_addr_q;
                                wr_data     <= wr_word;
                                if (reg_writable) begin
                                    regs_q[reg_addr_q[IDX_W-1:0]] <= wr_word;
                                end
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    default: begin
                        state_q   <= StIdle;
                        pre_cnt_q <= '0;
                        bit_cnt_q <= 4'd0;
                        mdio_oe   <= 1'b0;
                        mdio_o    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign debug_state = state_q;

endmodule
